nn_classify_ctrl: RTL and testbench

Initiator and result reader for the digit-classifier network. On a `Start` request it issues a one-cycle `Compute` to the network, waits for the network's `Ready`, snapshots the ten `Probability` words, then runs a sequential argmax and presents the winning digit and its score to the UI/display logic. The result is held under a `Valid`/`Ack` handshake. A watchdog bounds the wait.

---
 rtl/nn_classify_ctrl_pkg.sv | 16 +
 rtl/nn_classify_ctrl_argmax_seq.sv | 70 +++++++
 rtl/nn_classify_ctrl.sv | 101 ++++++++++
 tb/tb_nn_classify_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nn_classify_ctrl_pkg.sv
// Shared constants and controller state type for the digit-classifier network
// and its result reader.
package nn_classify_ctrl_pkg;

    localparam int NN_CLASSES = 10;
    localparam int NN_PROB_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRE,
        ST_WAIT,
        ST_SCAN,
        ST_HOLD
    } nn_ctrl_state_t;

endpackage

// File: rtl/nn_classify_ctrl_argmax_seq.sv
// Sequential argmax over a snapshot of the network's probability words:
// one compare per cycle, ties keep the lowest index.
module argmax_seq
    import nn_classify_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES = NN_CLASSES,
    parameter int PROB_W      = NN_PROB_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [PROB_W-1:0] probability [NUM_CLASSES-1:0],
    output logic              done,
    output logic [3:0]        digit,
    output logic [PROB_W-1:0] confidence
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    logic [PROB_W-1:0] snap [NUM_CLASSES-1:0];
    logic [3:0]        idx;
    logic [3:0]        best_idx;
    logic [3:0]        next_idx;
    logic [PROB_W-1:0] best_val;
    logic [PROB_W-1:0] next_val;
    logic              scanning;

    // Strictly-greater compare is what makes ties resolve to the lower index.
    always_comb begin
        next_val = best_val;
        next_idx = best_idx;
        if (snap[idx] > best_val) begin
            next_val = snap[idx];
            next_idx = idx;
        end
        done = scanning && (idx == LAST_IDX);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                snap[i] <= '0;
            end
            idx        <= '0;
            best_idx   <= '0;
            best_val   <= '0;
            scanning   <= 1'b0;
            digit      <= '0;
            confidence <= '0;
        end else if (start) begin
            snap     <= probability;
            best_val <= probability[0];
            best_idx <= '0;
            idx      <= 4'd1;
            scanning <= 1'b1;
        end else if (scanning) begin
            best_val <= next_val;
            best_idx <= next_idx;
            if (done) begin
                // Published result only changes when a full scan completes.
                scanning   <= 1'b0;
                digit      <= next_idx;
                confidence <= next_val;
            end else begin
                idx <= idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/nn_classify_ctrl.sv
// Classification controller: fires the network, waits for Ready under a
// watchdog, runs the argmax and holds the result under a Valid/Ack handshake.
module nn_classify_ctrl
    import nn_classify_ctrl_pkg::*;
#(
    parameter int NUM_CLASSES    = NN_CLASSES,
    parameter int PROB_W         = NN_PROB_W,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    output logic              Busy,
    output logic              Compute,
    input  logic              Ready,
    input  logic [PROB_W-1:0] Probability [NUM_CLASSES-1:0],
    output logic [3:0]        Digit,
    output logic [PROB_W-1:0] Confidence,
    output logic              Valid,
    input  logic              Ack,
    output logic              Timeout
);

    localparam logic [11:0] WD_LAST = 12'(TIMEOUT_CYCLES - 1);

    nn_ctrl_state_t state;
    nn_ctrl_state_t next_state;
    logic           ready_q;
    logic [11:0]    wd_cnt;
    logic           timeout_q;
    logic           ready_edge;
    logic           wd_expired;
    logic           scan_start;
    logic           scan_done;

    assign ready_edge = Ready & ~ready_q;
    assign wd_expired = (wd_cnt == WD_LAST);
    assign scan_start = (state == ST_WAIT) && ready_edge;
    assign Timeout    = timeout_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b0;
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state   <= next_state;
            ready_q <= Ready;
            if (state == ST_FIRE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 12'd1;
            end
            if (state == ST_IDLE && Start) begin
                timeout_q <= 1'b0;
            end else if (state == ST_WAIT && !ready_edge && wd_expired) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // A Ready edge wins over a watchdog expiry in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: if (Start) next_state = ST_FIRE;
            ST_FIRE: next_state = ST_WAIT;
            ST_WAIT: begin
                if (ready_edge) begin
                    next_state = ST_SCAN;
                end else if (wd_expired) begin
                    next_state = ST_IDLE;
                end
            end
            ST_SCAN: if (scan_done) next_state = ST_HOLD;
            ST_HOLD: if (Ack) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state != ST_IDLE);
        Compute = (state == ST_FIRE);
        Valid   = (state == ST_HOLD);
    end

    argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .PROB_W      (PROB_W)
    ) u_argmax (
        .clk         (Clk),
        .reset_n     (Reset_n),
        .start       (scan_start),
        .probability (Probability),
        .done        (scan_done),
        .digit       (Digit),
        .confidence  (Confidence)
    );

endmodule

// File: tb/tb_nn_classify_ctrl.sv
// Randomised and directed bench for nn_classify_ctrl, checked against a
// plain argmax / cycle-count reference model.
module tb_nn_classify_ctrl;

    localparam int T = 64;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Start;
    logic        Busy;
    logic        Compute;
    logic        Ready;
    logic [15:0] Probability [9:0];
    logic [3:0]  Digit;
    logic [15:0] Confidence;
    logic        Valid;
    logic        Ack;
    logic        Timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int compute_pulses = 0;

    nn_classify_ctrl #(
        .NUM_CLASSES    (10),
        .PROB_W         (16),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Start       (Start),
        .Busy        (Busy),
        .Compute     (Compute),
        .Ready       (Ready),
        .Probability (Probability),
        .Digit       (Digit),
        .Confidence  (Confidence),
        .Valid       (Valid),
        .Ack         (Ack),
        .Timeout     (Timeout)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && Compute === 1'b1) compute_pulses++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL global_timeout observed=hung expected=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the maximum value.
    function automatic int refArgmax(input logic [15:0] p [9:0]);
        int best = 0;
        for (int i = 1; i < 10; i++) begin
            if (p[i] > p[best]) best = i;
        end
        return best;
    endfunction

    task automatic applyStimulus(input string name, input logic [15:0] p [9:0],
                                 input int ready_delay, input bit corrupt, input bit start_noise);
        int c0;
        int exp_idx;
        logic [15:0] exp_val;
        c0 = compute_pulses;
        Probability = p;
        exp_idx = refArgmax(p);
        exp_val = p[exp_idx];
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checkOutput({name, "_compute"}, {31'd0, Compute}, 32'd1);
        for (int i = 0; i < ready_delay; i++) begin
            Start = start_noise ? 1'(i % 2) : 1'b0;
            tick();
        end
        Start = 1'b0;
        Ready = 1'b1;
        tick();
        if (corrupt) begin
            Probability[3] = 16'hFFFF;
            Probability[0] = 16'hFFFE;
        end
        repeat (8) tick();
        checkOutput({name, "_valid_early"}, {31'd0, Valid}, 32'd0);
        tick();
        checkOutput({name, "_valid"}, {31'd0, Valid}, 32'd1);
        checkOutput({name, "_digit"}, {28'd0, Digit}, 32'(exp_idx));
        checkOutput({name, "_conf"}, {16'd0, Confidence}, {16'd0, exp_val});
        if (start_noise) begin
            Start = 1'b1;
            tick();
            Start = 1'b0;
            tick();
            checkOutput({name, "_hold_valid"}, {31'd0, Valid}, 32'd1);
            checkOutput({name, "_hold_digit"}, {28'd0, Digit}, 32'(exp_idx));
        end
        Ready = 1'b0;
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        checkOutput({name, "_ack_valid"}, {31'd0, Valid}, 32'd0);
        checkOutput({name, "_ack_busy"}, {31'd0, Busy}, 32'd0);
        tick();
        checkOutput({name, "_pulses"}, 32'(compute_pulses - c0), 32'd1);
    endtask

    task automatic runTimeout(input string name, input logic ready_level);
        int c0;
        c0 = compute_pulses;
        Ready = ready_level;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checkOutput({name, "_clears"}, {31'd0, Timeout}, 32'd0);
        tick();
        repeat (T - 1) tick();
        checkOutput({name, "_before"}, {30'd0, Timeout, Busy}, 32'd1);
        tick();
        checkOutput({name, "_after"}, {30'd0, Timeout, Busy}, 32'd2);
        checkOutput({name, "_valid"}, {31'd0, Valid}, 32'd0);
        checkOutput({name, "_pulses"}, 32'(compute_pulses - c0), 32'd1);
        Ready = 1'b0;
        tick();
    endtask

    initial begin
        logic [15:0] p [9:0];
        int c0;

        Reset_n = 1'b0;
        Start   = 1'b1;
        Ready   = 1'b0;
        Ack     = 1'b0;
        for (int i = 0; i < 10; i++) Probability[i] = 16'h0;
        repeat (3) tick();
        checkOutput("reset_busy", {31'd0, Busy}, 32'd0);
        checkOutput("reset_compute", {31'd0, Compute}, 32'd0);
        checkOutput("reset_valid", {31'd0, Valid}, 32'd0);
        checkOutput("reset_timeout", {31'd0, Timeout}, 32'd0);
        checkOutput("reset_digit", {28'd0, Digit}, 32'd0);
        checkOutput("reset_conf", {16'd0, Confidence}, 32'd0);
        Start = 1'b0;
        Reset_n = 1'b1;
        tick();

        // Basic: ramp with a clear peak at 7
        for (int i = 0; i < 10; i++) p[i] = 16'(i * 16'h0100);
        p[7] = 16'h0F00;
        applyStimulus("basic", p, 50, 1'b0, 1'b1);

        for (int i = 0; i < 10; i++) p[i] = 16'h0010;
        p[2] = 16'h07FF;
        p[5] = 16'h07FF;
        applyStimulus("tie", p, 5, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) p[i] = 16'h0000;
        applyStimulus("zeros", p, 3, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) p[i] = 16'(16'h0100 + i);
        applyStimulus("isolate", p, 7, 1'b1, 1'b0);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 10; i++) p[i] = 16'($urandom);
            if (t % 2 == 1) p[$urandom_range(9, 5)] = p[$urandom_range(4, 0)] | 16'h8000;
            if (t % 3 == 2) p[9] = 16'hFFFF;
            applyStimulus("random", p, int'($urandom_range(40, 1)), 1'b0, 1'(t % 2));
        end

        runTimeout("timeout_low", 1'b0);
        runTimeout("timeout_high", 1'b1);

        // Start and Ack together in HOLD: Ack wins, Start is dropped
        for (int i = 0; i < 10; i++) p[i] = 16'(16'h0200 - i);
        Probability = p;
        c0 = compute_pulses;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (4) tick();
        Ready = 1'b1;
        repeat (10) tick();
        checkOutput("startack_valid", {31'd0, Valid}, 32'd1);
        Start = 1'b1;
        Ack = 1'b1;
        tick();
        Start = 1'b0;
        Ack = 1'b0;
        Ready = 1'b0;
        checkOutput("startack_busy", {30'd0, Busy, Valid}, 32'd0);
        repeat (5) tick();
        checkOutput("startack_no_fire", 32'(compute_pulses - c0), 32'd1);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checkOutput("startack_refire", {31'd0, Compute}, 32'd1);

        // Asynchronous reset in the middle of a scan
        repeat (3) tick();
        Ready = 1'b1;
        repeat (3) tick();
        checkOutput("midscan_busy_pre", {31'd0, Busy}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("midscan_busy", {31'd0, Busy}, 32'd0);
        checkOutput("midscan_digit", {28'd0, Digit}, 32'd0);
        checkOutput("midscan_conf", {16'd0, Confidence}, 32'd0);
        checkOutput("midscan_valid", {30'd0, Valid, Timeout}, 32'd0);
        Ready = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        repeat (12) tick();
        checkOutput("midscan_idle", {30'd0, Busy, Valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
